// File: rtl/alu_seq.sv
// Registered, handshaked ALU: single-cycle logic/arith/shift ops plus a
// WIDTH-cycle shift-add unsigned multiply, one operation in flight at a time.
module alu_seq #(
    parameter int WIDTH = 8,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             cout,
    output logic             zero,
    output logic             neg,
    output logic             ovf,
    output logic             illegal,
    output logic             busy
);

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_XOR = 4'd2;
    localparam logic [3:0] OP_ADD = 4'd3;
    localparam logic [3:0] OP_SUB = 4'd4;
    localparam logic [3:0] OP_SHL = 4'd5;
    localparam logic [3:0] OP_SHR = 4'd6;
    localparam logic [3:0] OP_MUL = 4'd7;

    typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;

    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   res_hi_q, res_hi_d;
    logic               cout_q, cout_d;
    logic               zero_q, zero_d;
    logic               neg_q, neg_d;
    logic               ovf_q, ovf_d;
    logic               illegal_q, illegal_d;

    logic [WIDTH:0]     sum, diff, mul_sum;
    logic [WIDTH-1:0]   alu_res, mul_addend;
    logic [2*WIDTH-1:0] mul_prod;
    logic               alu_cout, alu_ovf, alu_illegal;
    logic               accept, handshake;

    always_comb begin
        alu_res     = '0;
        alu_cout    = 1'b0;
        alu_ovf     = 1'b0;
        alu_illegal = 1'b0;
        sum  = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
        diff = {1'b0, a} - {1'b0, b} - (WIDTH+1)'(cin);
        case (op)
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_ADD: begin
                alu_res  = sum[WIDTH-1:0];
                alu_cout = sum[WIDTH];
                alu_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                // Bit WIDTH of the widened difference is the unsigned borrow
                alu_res  = diff[WIDTH-1:0];
                alu_cout = diff[WIDTH];
                alu_ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SHL: alu_res = a << b[SHW-1:0];
            OP_SHR: alu_res = a >> b[SHW-1:0];
            OP_MUL: ;
            default: alu_illegal = 1'b1;
        endcase
    end

    // Right-shifting accumulator: each step adds the multiplicand into the high
    // half and shifts one finished product bit down into the low half.
    always_comb begin
        mul_addend = mplier_q[0] ? mcand_q : '0;
        mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
        mul_prod   = {mul_sum, acc_q[WIDTH-1:1]};
    end

    assign in_ready  = !rst && (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign handshake = out_valid_q && out_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        out_valid_d = handshake ? 1'b0 : out_valid_q;
        res_d       = res_q;
        res_hi_d    = res_hi_q;
        cout_d      = cout_q;
        zero_d      = zero_q;
        neg_d       = neg_q;
        ovf_d       = ovf_q;
        illegal_d   = illegal_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (op == OP_MUL) begin
                        mcand_d  = a;
                        mplier_d = b;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = MUL;
                    end else begin
                        out_valid_d = 1'b1;
                        res_d       = alu_res;
                        res_hi_d    = '0;
                        cout_d      = alu_cout;
                        zero_d      = (alu_res == '0);
                        neg_d       = alu_res[WIDTH-1];
                        ovf_d       = alu_ovf;
                        illegal_d   = alu_illegal;
                    end
                end
            end
            MUL: begin
                acc_d    = mul_prod;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + SHW'(1);
                if (cnt_q == SHW'(WIDTH-1)) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b1;
                    res_d       = mul_prod[WIDTH-1:0];
                    res_hi_d    = mul_prod[2*WIDTH-1:WIDTH];
                    cout_d      = (mul_prod[2*WIDTH-1:WIDTH] != '0);
                    zero_d      = (mul_prod == '0);
                    neg_d       = mul_prod[2*WIDTH-1];
                    ovf_d       = 1'b0;
                    illegal_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            res_hi_q    <= '0;
            cout_q      <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            ovf_q       <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
            res_hi_q    <= res_hi_d;
            cout_q      <= cout_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
            ovf_q       <= ovf_d;
            illegal_q   <= illegal_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = res_q;
    assign result_hi = res_hi_q;
    assign cout      = cout_q;
    assign zero      = zero_q;
    assign neg       = neg_q;
    assign ovf       = ovf_q;
    assign illegal   = illegal_q;
    assign busy      = (state_q == MUL);

endmodule
